// File: rtl/pci_target_0101.sv
// PCI 32-bit memory target with a 4-entry buffer, address/data parity
// checking and a STOPn disconnect when a burst runs past the buffer depth.
module pci_target_0101 #(
    parameter logic [31:0] BASE_ADDR = 32'h000AAAA0,
    parameter int          DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [31:0] AD,
    input  logic [3:0]  CBEn,
    inout  wire         PAR,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic        IDSEL,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        DEVSELn,
    output logic        PERRn,
    output logic        SERRn
);
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [2:0] LAST_IDX      = 3'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_TA,
        S_READ,
        S_DISC,
        S_TURN,
        S_BUSY
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data;
    logic        hit;
    logic        xfer;
    logic        ad_oe;
    logic        addr_chk;
    logic        data_chk;
    logic        phase_par;
    logic        par_oe;
    logic        par_out;
    logic        unused_idsel;

    assign unused_idsel = IDSEL;
    assign hit          = (AD[31:4] == BASE_ADDR[31:4]);
    assign xfer         = !IRDYn && !TRDYn;
    assign ad_oe        = (state == S_READ);
    assign AD           = ad_oe ? rd_data : 32'bz;
    assign PAR          = par_oe ? par_out : 1'bz;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        TRDYn      = 1'b1;
        STOPn      = 1'b1;
        DEVSELn    = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!FRAMEn) begin
                    if (hit && CBEn == CMD_MEM_WRITE)     state_next = S_WRITE;
                    else if (hit && CBEn == CMD_MEM_READ) state_next = S_READ_TA;
                    else                                  state_next = S_BUSY;
                end
            end
            S_WRITE, S_READ: begin
                DEVSELn = 1'b0;
                TRDYn   = 1'b0;
                if (!IRDYn) begin
                    if (FRAMEn)               state_next = S_TURN;
                    else if (idx == LAST_IDX) state_next = S_DISC;
                end
            end
            S_READ_TA: begin
                DEVSELn    = 1'b0;
                state_next = S_READ;
            end
            S_DISC: begin
                DEVSELn = 1'b0;
                STOPn   = 1'b0;
                if (FRAMEn) state_next = S_TURN;
            end
            S_TURN: state_next = S_IDLE;
            S_BUSY: if (FRAMEn && IRDYn) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Read data is the current entry with disabled byte lanes forced to zero.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < 4; b++)
            rd_data[8*b +: 8] = CBEn[b] ? 8'h00 : mem[idx[1:0]][8*b +: 8];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (state == S_IDLE) idx <= '0;
            else if (xfer)       idx <= idx + 3'd1;
            if (state == S_WRITE && xfer) begin
                for (int b = 0; b < 4; b++)
                    if (!CBEn[b]) mem[idx[1:0]][8*b +: 8] <= AD[8*b +: 8];
            end
        end
    end

    // PAR trails its phase by one clock, so the phase parity is held a cycle
    // and compared when PAR arrives; the error flag follows one clock later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_chk  <= 1'b0;
            data_chk  <= 1'b0;
            phase_par <= 1'b0;
            par_oe    <= 1'b0;
            par_out   <= 1'b0;
            SERRn     <= 1'b1;
            PERRn     <= 1'b1;
        end else begin
            addr_chk  <= (state == S_IDLE) && !FRAMEn;
            data_chk  <= (state == S_WRITE) && xfer;
            phase_par <= ^{AD, CBEn};
            par_oe    <= ad_oe;
            par_out   <= ^{rd_data, CBEn};
            SERRn     <= !(addr_chk && (phase_par ^ PAR));
            PERRn     <= !(data_chk && (phase_par ^ PAR));
        end
    end
endmodule

// File: tb/tb_pci_target_0101.sv
// Cycle-table bench for pci_target_0101: each row is one bus clock of master
// stimulus plus the target outputs expected during that clock.
module tb_pci_target_0101;
    localparam logic [4:0] C_IDLE = 5'b11111;  // {TRDYn,STOPn,DEVSELn,PERRn,SERRn}
    localparam logic [4:0] C_XFER = 5'b01011;
    localparam logic [4:0] C_TA   = 5'b11011;
    localparam logic [4:0] C_DISC = 5'b10011;
    localparam logic [1:0] PM_NONE = 2'd0;
    localparam logic [1:0] PM_GOOD = 2'd1;
    localparam logic [1:0] PM_BAD  = 2'd2;
    localparam logic [3:0] RD = 4'b0110;
    localparam logic [3:0] WR = 4'b0111;

    typedef struct {
        logic        frame_n;
        logic        irdy_n;
        logic [3:0]  cbe;
        logic        drv;
        logic [31:0] ad;
        logic [1:0]  pm;
        logic [4:0]  exp_ctl;
        logic        chk_ad;
        logic [31:0] exp_ad;
        logic        chk_par;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_n, irdy_n, idsel;
    logic [3:0]  cbe_n;
    logic        tb_drv, tb_par_oe, tb_par;
    logic [31:0] tb_ad;
    wire  [31:0] ad_bus;
    wire         par_bus;
    logic        trdy_n, stop_n, devsel_n, perr_n, serr_n;
    logic [31:0] last_ad;
    logic [3:0]  last_cbe;
    row_t        tbl[$];
    int          n_compared = 0;
    int          n_mismatched = 0;

    assign ad_bus  = tb_drv ? tb_ad : 32'bz;
    assign par_bus = tb_par_oe ? tb_par : 1'bz;

    always #5 clk = ~clk;

    pci_target_0101 dut (
        .CLK(clk), .RST(rst), .AD(ad_bus), .CBEn(cbe_n), .PAR(par_bus),
        .FRAMEn(frame_n), .IRDYn(irdy_n), .IDSEL(idsel), .TRDYn(trdy_n),
        .STOPn(stop_n), .DEVSELn(devsel_n), .PERRn(perr_n), .SERRn(serr_n)
    );

    function automatic row_t drv_row(input logic fr, input logic ir, input logic [3:0] cbe,
                                     input logic [31:0] ad, input logic [1:0] pm,
                                     input logic [4:0] ctl);
        row_t r;
        r = '{frame_n: fr, irdy_n: ir, cbe: cbe, drv: 1'b1, ad: ad, pm: pm,
              exp_ctl: ctl, chk_ad: 1'b0, exp_ad: 32'h0, chk_par: 1'b0};
        return r;
    endfunction

    function automatic row_t rd_row(input logic fr, input logic ir, input logic [3:0] cbe,
                                    input logic [1:0] pm, input logic [4:0] ctl,
                                    input logic cad, input logic [31:0] ead, input logic cpar);
        row_t r;
        r = '{frame_n: fr, irdy_n: ir, cbe: cbe, drv: 1'b0, ad: 32'h0, pm: pm,
              exp_ctl: ctl, chk_ad: cad, exp_ad: ead, chk_par: cpar};
        return r;
    endfunction

    function automatic row_t idle_row();
        return rd_row(1'b1, 1'b1, 4'hF, PM_NONE, C_IDLE, 1'b0, 32'h0, 1'b0);
    endfunction

    task automatic check_val(input string name, input int row, input logic [31:0] got,
                             input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row, got, want);
        end
    endtask

    task automatic check_ctl(input string name, input int row, input logic [4:0] want);
        n_compared++;
        if ({trdy_n, stop_n, devsel_n, perr_n, serr_n} !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s row %0d ctl {TRDYn,STOPn,DEVSELn,PERRn,SERRn}: got %b, expected %b",
                     name, row, {trdy_n, stop_n, devsel_n, perr_n, serr_n}, want);
        end
    endtask

    // PAR on each row belongs to the previous row's AD/CBEn.
    task automatic apply_stimulus(input row_t r, output logic prev_par);
        prev_par  = ^{last_ad, last_cbe};
        frame_n   = r.frame_n;
        irdy_n    = r.irdy_n;
        cbe_n     = r.cbe;
        tb_drv    = r.drv;
        tb_ad     = r.ad;
        tb_par_oe = (r.pm != PM_NONE);
        tb_par    = prev_par ^ (r.pm == PM_BAD);
        last_ad   = r.drv ? r.ad : (r.chk_ad ? r.exp_ad : 32'h0);
        last_cbe  = r.cbe;
    endtask

    task automatic check_output(input row_t r, input string name, input int row, input logic prev_par);
        check_ctl(name, row, r.exp_ctl);
        if (r.chk_ad)  check_val({name, "_ad"}, row, ad_bus, r.exp_ad);
        if (r.chk_par) check_val({name, "_par"}, row, {31'b0, par_bus}, {31'b0, prev_par});
    endtask

    task automatic run_table(input string name);
        logic p;
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], p);
            @(negedge clk);
            check_output(tbl[i], name, i, p);
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic queue_read4(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        tbl.push_back(drv_row(1'b0, 1'b1, RD, 32'h000AAAAC, PM_NONE, C_IDLE));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_GOOD, C_TA, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, w0, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, w1, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, w2, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, w3, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_NONE, C_IDLE, 1'b0, 32'h0, 1'b1));
        tbl.push_back(idle_row());
    endtask

    initial begin
        rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; idsel = 1'b0;
        tb_drv = 1'b0; tb_ad = 32'h0; tb_par_oe = 1'b0; tb_par = 1'b0;
        last_ad = 32'h0; last_cbe = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        check_ctl("reset", 0, C_IDLE);
        rst = 1'b0;

        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000AAAAA, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h000AABAA, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h000CABAA, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h000CABFA, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'h0, 32'h000CABAB, PM_GOOD, C_XFER));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        run_table("write4");

        // Address miss, then a hit with an unsupported command: both ignored.
        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000BBBB0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h11111111, PM_GOOD, C_IDLE));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'h0, 32'h22222222, PM_GOOD, C_IDLE));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(drv_row(1'b0, 1'b1, 4'b0010, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'h0, 32'h33333333, PM_GOOD, C_IDLE));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        run_table("ignored");

        queue_read4(32'h000AABAA, 32'h000CABAA, 32'h000CABFA, 32'h000CABAB);
        run_table("read4");

        // Bad address parity -> SERRn in row 2; bad data2 parity -> PERRn in row 4.
        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h12345678, PM_BAD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h9ABCDEF0, PM_GOOD, 5'b01010));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h0F0F0F0F, PM_BAD, C_XFER));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'h0, 32'hF0F0F0F0, PM_GOOD, 5'b01001));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        run_table("parity_err");

        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'hDEADBEEF, PM_GOOD, C_XFER));
        run_table("abort_write");
        rst = 1'b1;
        #1;
        check_ctl("async_reset", 0, C_IDLE);
        frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; tb_drv = 1'b0; tb_par_oe = 1'b0;
        last_ad = 32'h0; last_cbe = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'b0001, 32'hFFFFFFFF, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'b0010, 32'hFFFFFFFF, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'b0100, 32'hFFFFFFFF, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'b1000, 32'hFFFFFFFF, PM_GOOD, C_XFER));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        queue_read4(32'hFFFFFF00, 32'hFFFF00FF, 32'hFF00FFFF, 32'h00FFFFFF);
        run_table("byte_mask");

        // Fifth data phase meets STOPn and must not be stored.
        tbl.push_back(drv_row(1'b0, 1'b1, WR, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h01020304, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h05060708, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h090A0B0C, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b0, 1'b0, 4'h0, 32'h0D0E0F10, PM_GOOD, C_XFER));
        tbl.push_back(drv_row(1'b1, 1'b0, 4'h0, 32'h000CABAF, PM_GOOD, C_DISC));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_GOOD, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        run_table("overflow_write");

        tbl.push_back(drv_row(1'b0, 1'b1, RD, 32'h000AAAA4, PM_NONE, C_IDLE));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_GOOD, C_TA, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h01020304, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h05060708, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h090A0B0C, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h0D0E0F10, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b0, 4'h0, PM_NONE, C_DISC, 1'b0, 32'h0, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_NONE, C_IDLE, 1'b0, 32'h0, 1'b0));
        tbl.push_back(idle_row());
        run_table("overflow_read");

        // Master wait states between every read phase.
        tbl.push_back(drv_row(1'b0, 1'b1, RD, 32'h000AAAA8, PM_NONE, C_IDLE));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'h0, PM_GOOD, C_TA, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h01020304, 1'b0));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h01020304, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h05060708, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h05060708, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h090A0B0C, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h090A0B0C, 1'b1));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h0D0E0F10, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b0, 4'h0, PM_NONE, C_XFER, 1'b1, 32'h0D0E0F10, 1'b1));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_NONE, C_IDLE, 1'b0, 32'h0, 1'b1));
        tbl.push_back(idle_row());
        run_table("irdy_wait");

        // Single-phase read with byte lanes 0 and 2 disabled.
        tbl.push_back(drv_row(1'b0, 1'b1, RD, 32'h000AAAA0, PM_NONE, C_IDLE));
        tbl.push_back(rd_row(1'b0, 1'b1, 4'b0101, PM_GOOD, C_TA, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd_row(1'b1, 1'b0, 4'b0101, PM_NONE, C_XFER, 1'b1, 32'h01000300, 1'b0));
        tbl.push_back(rd_row(1'b1, 1'b1, 4'hF, PM_NONE, C_IDLE, 1'b0, 32'h0, 1'b1));
        tbl.push_back(idle_row());
        run_table("read_mask");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
